// File: rtl/ram_block_loader.sv
// ram_block_loader: sequential write-then-verify master for the RAM block port.
//
// Accepts a stream of 32-bit words over a valid/ready handshake. Each word is
// written to a consecutive RAM address starting at a captured base. The same
// range is then read back, and the read-back sum is compared with the write sum.
//
// Ports:
//   Clk, Reset            clock, asynchronous active-high reset
//   Start                 begin a load (sampled in idle only)
//   Base_Addr, Length     first address and word count, captured on Start
//   Data_In, Data_Valid   stream word and its valid flag
//   Data_Ready            loader accepts Data_In this cycle
//   Enable, RW, Address   RAM control (RW: 1 = read, 0 = write)
//   Ram_In, Ram_Out       RAM write data / combinational read data
//   Busy, Done            operation in progress / one-cycle completion pulse
//   Pass, Checksum        verify result and write sum, held until next Start

module ram_block_loader (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] Base_Addr,
  input  logic [15:0] Length,
  input  logic [31:0] Data_In,
  input  logic        Data_Valid,
  output logic        Data_Ready,
  output logic        Enable,
  output logic        RW,
  output logic [15:0] Address,
  output logic [31:0] Ram_In,
  input  logic [31:0] Ram_Out,
  output logic        Busy,
  output logic        Done,
  output logic        Pass,
  output logic [31:0] Checksum
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StFinish} state_e;

  state_e      state_q;
  logic [15:0] base_q, len_q, cnt_q, remain_q;
  // Last values driven onto the RAM port; outputs hold these when idle.
  logic [15:0] addr_last_q;
  logic [31:0] data_last_q;
  logic [31:0] wsum_q, rsum_q, checksum_q;
  logic        busy_q, done_q, pass_q;

  logic        wr_fire, rd_fire, last_word;
  logic [31:0] rsum_next;

  assign wr_fire   = (state_q == StWrite) && Data_Valid;
  assign rd_fire   = (state_q == StRead);
  assign last_word = (remain_q == 16'd1);
  // Includes the word being read this cycle, so the last compare sees the full sum.
  assign rsum_next = rsum_q + Ram_Out;

  always_comb begin
    Data_Ready = (state_q == StWrite);
    Enable     = wr_fire | rd_fire;
    RW         = ~wr_fire;
    Address    = (wr_fire | rd_fire) ? cnt_q : addr_last_q;
    Ram_In     = wr_fire ? Data_In : data_last_q;
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Pass     = pass_q;
  assign Checksum = checksum_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      base_q      <= 16'd0;
      len_q       <= 16'd0;
      cnt_q       <= 16'd0;
      remain_q    <= 16'd0;
      addr_last_q <= 16'd0;
      data_last_q <= 32'd0;
      wsum_q      <= 32'd0;
      rsum_q      <= 32'd0;
      checksum_q  <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (wr_fire | rd_fire) addr_last_q <= cnt_q;
      if (wr_fire)           data_last_q <= Data_In;

      unique case (state_q)
        StIdle: begin
          if (Start) begin
            base_q     <= Base_Addr;
            len_q      <= Length;
            cnt_q      <= Base_Addr;
            remain_q   <= Length;
            wsum_q     <= 32'd0;
            rsum_q     <= 32'd0;
            checksum_q <= 32'd0;
            busy_q     <= 1'b1;
            if (Length == 16'd0) begin
              // Empty load: both sums are zero, so the verify trivially passes.
              state_q <= StFinish;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              state_q <= StWrite;
              pass_q  <= 1'b0;
            end
          end
        end
        StWrite: begin
          if (Data_Valid) begin
            wsum_q <= wsum_q + Data_In;
            if (last_word) begin
              cnt_q    <= base_q;
              remain_q <= len_q;
              state_q  <= StRead;
            end else begin
              cnt_q    <= cnt_q + 16'd1;
              remain_q <= remain_q - 16'd1;
            end
          end
        end
        StRead: begin
          rsum_q   <= rsum_next;
          cnt_q    <= cnt_q + 16'd1;
          remain_q <= remain_q - 16'd1;
          if (last_word) begin
            // Result registered on entry to finish so it is valid with Done.
            state_q    <= StFinish;
            done_q     <= 1'b1;
            pass_q     <= (rsum_next == wsum_q);
            checksum_q <= wsum_q;
          end
        end
        StFinish: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_block_loader.sv
module tb_ram_block_loader;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [15:0] Base_Addr = 16'd0;
  logic [15:0] Length = 16'd0;
  logic [31:0] Data_In = 32'd0;
  logic        Data_Valid = 1'b0;
  logic        Data_Ready, Enable, RW, Busy, Done, Pass;
  logic [15:0] Address;
  logic [31:0] Ram_In, Ram_Out, Checksum;

  ram_block_loader dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Base_Addr  (Base_Addr),
    .Length     (Length),
    .Data_In    (Data_In),
    .Data_Valid (Data_Valid),
    .Data_Ready (Data_Ready),
    .Enable     (Enable),
    .RW         (RW),
    .Address    (Address),
    .Ram_In     (Ram_In),
    .Ram_Out    (Ram_Out),
    .Busy       (Busy),
    .Done       (Done),
    .Pass       (Pass),
    .Checksum   (Checksum)
  );

  always #5 Clk = ~Clk;

  // RAM model: synchronous write, combinational read, optional bit-0 corruption at address 2.
  logic [31:0] mem [0:65535];
  logic        corrupt = 1'b0;
  assign Ram_Out = (corrupt && Address == 16'd2) ? (mem[Address] ^ 32'h1) : mem[Address];
  always @(posedge Clk) if (Enable && !RW) mem[Address] <= Ram_In;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Bus log collected at the falling edge.
  int          wr_cyc[$];
  logic [15:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          rd_cyc[$];
  logic [15:0] rd_addr[$];

  always @(negedge Clk) begin
    if (Enable === 1'b1) begin
      if (RW === 1'b0) begin
        wr_cyc.push_back(cyc);
        wr_addr.push_back(Address);
        wr_data.push_back(Ram_In);
      end else begin
        rd_cyc.push_back(cyc);
        rd_addr.push_back(Address);
      end
    end
  end

  logic [31:0] words[$];
  int          done_cyc;
  logic        busy_at_done, busy_after, pass_at_done;
  logic [31:0] sum_at_done;

  // Reset values packed as {Enable,RW,Address,Ram_In,Data_Ready,Busy,Done,Pass,Checksum}.
  localparam logic [85:0] ResetVec = {1'b0, 1'b1, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

  task automatic clear_log();
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
    rd_cyc.delete(); rd_addr.delete();
  endtask

  // Runs one load of `words`; records Done cycle, Busy around Done and the result.
  task automatic run_load(input logic [15:0] base, input logic [15:0] len, input bit stall,
                          input bit poke_start);
    int idx;
    clear_log();
    @(posedge Clk); #1;
    Start = 1'b1; Base_Addr = base; Length = len;
    @(posedge Clk); #1;
    Start = 1'b0; Base_Addr = 16'h1234; Length = 16'd7;
    idx = 0; done_cyc = -1; busy_after = 1'bx; busy_at_done = 1'bx;
    pass_at_done = 1'bx; sum_at_done = 32'hx;
    for (int c = 1; c <= 100; c++) begin
      cyc = c;
      if (idx < words.size() && !(stall && (c % 2 == 0))) begin
        Data_Valid = 1'b1; Data_In = words[idx];
      end else begin
        Data_Valid = 1'b0; Data_In = 32'hDEAD_BEEF;
      end
      Start = poke_start && (c == 2 || c == int'(len) + 2);
      @(negedge Clk);
      if (Data_Valid && Data_Ready) idx++;
      if (done_cyc > 0 && c == done_cyc + 1) begin
        busy_after = Busy;
        break;
      end
      if (Done === 1'b1 && done_cyc < 0) begin
        done_cyc = c; busy_at_done = Busy; pass_at_done = Pass; sum_at_done = Checksum;
      end
      @(posedge Clk); #1;
    end
    Data_Valid = 1'b0; Start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({Enable, RW, Address, Ram_In, Data_Ready, Busy, Done, Pass, Checksum} !== ResetVec) begin
      n_bad++;
      $display("FAIL reset_values got %h want %h",
               {Enable, RW, Address, Ram_In, Data_Ready, Busy, Done, Pass, Checksum}, ResetVec);
    end
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_basic(input string name, input bit stall);
    words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;
    run_load(16'h0000, 16'd4, stall, 1'b0);
    n_cmp++;
    if (wr_cyc.size() != 4 || rd_cyc.size() != 4) begin
      n_bad++;
      $display("FAIL %s_counts got wr=%0d rd=%0d want wr=4 rd=4", name, wr_cyc.size(),
               rd_cyc.size());
    end
    for (int i = 0; i < 4 && i < wr_cyc.size(); i++) begin
      n_cmp++;
      // No stalls: writes in cycles 1..4. Stalls on even cycles: writes in 1,3,5,7.
      if ({wr_cyc[i], wr_addr[i], wr_data[i]} !==
          {(stall ? 2 * i + 1 : i + 1), 16'(i), words[i]}) begin
        n_bad++;
        $display("FAIL %s_write%0d got cyc=%0d addr=%h data=%h want addr=%h data=%h", name, i,
                 wr_cyc[i], wr_addr[i], wr_data[i], 16'(i), words[i]);
      end
    end
    for (int i = 0; i < 4 && i < rd_cyc.size(); i++) begin
      n_cmp++;
      if ({rd_cyc[i], rd_addr[i]} !== {(stall ? 8 + i : 5 + i), 16'(i)}) begin
        n_bad++;
        $display("FAIL %s_read%0d got cyc=%0d addr=%h want cyc=%0d addr=%h", name, i,
                 rd_cyc[i], rd_addr[i], (stall ? 8 + i : 5 + i), 16'(i));
      end
    end
    n_cmp++;
    if ({done_cyc, busy_at_done, busy_after} !== {(stall ? 12 : 9), 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL %s_done got cyc=%0d busy=%b busy_next=%b want cyc=%0d busy=1 busy_next=0",
               name, done_cyc, busy_at_done, busy_after, (stall ? 12 : 9));
    end
    n_cmp++;
    if ({pass_at_done, sum_at_done} !== {1'b1, 32'hAAAAAAAA}) begin
      n_bad++;
      $display("FAIL %s_result got pass=%b sum=%h want pass=1 sum=aaaaaaaa", name,
               pass_at_done, sum_at_done);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem[i] !== words[i]) begin
        n_bad++;
        $display("FAIL %s_mem%0d got %h want %h", name, i, mem[i], words[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] ea [3];
    ea = '{16'hFFFE, 16'hFFFF, 16'h0000};
    words = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    run_load(16'hFFFE, 16'd3, 1'b0, 1'b0);
    n_cmp++;
    if (wr_addr.size() != 3 || rd_addr.size() != 3) begin
      n_bad++;
      $display("FAIL wrap_counts got wr=%0d rd=%0d want 3 3", wr_addr.size(), rd_addr.size());
    end
    for (int i = 0; i < 3 && i < wr_addr.size() && i < rd_addr.size(); i++) begin
      n_cmp++;
      if ({wr_addr[i], rd_addr[i]} !== {ea[i], ea[i]}) begin
        n_bad++;
        $display("FAIL wrap_addr%0d got wr=%h rd=%h want %h", i, wr_addr[i], rd_addr[i], ea[i]);
      end
    end
    n_cmp++;
    if ({done_cyc, pass_at_done, sum_at_done} !== {7, 1'b1, 32'hFFFFFFFD}) begin
      n_bad++;
      $display("FAIL wrap_result got done=%0d pass=%b sum=%h want done=7 pass=1 sum=fffffffd",
               done_cyc, pass_at_done, sum_at_done);
    end
  endtask

  task automatic test_corrupt();
    words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    corrupt = 1'b1;
    run_load(16'h0000, 16'd4, 1'b0, 1'b0);
    corrupt = 1'b0;
    n_cmp++;
    if ({done_cyc, pass_at_done, sum_at_done} !== {9, 1'b0, 32'hAAAAAAAA}) begin
      n_bad++;
      $display("FAIL corrupt_result got done=%0d pass=%b sum=%h want done=9 pass=0 sum=aaaaaaaa",
               done_cyc, pass_at_done, sum_at_done);
    end
  endtask

  task automatic test_zero_len();
    words.delete();
    run_load(16'h0040, 16'd0, 1'b0, 1'b0);
    n_cmp++;
    if ({done_cyc, busy_at_done, busy_after, pass_at_done, sum_at_done} !==
        {1, 1'b1, 1'b0, 1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL zero_len got done=%0d busy=%b busy_next=%b pass=%b sum=%h want 1 1 0 1 0",
               done_cyc, busy_at_done, busy_after, pass_at_done, sum_at_done);
    end
    n_cmp++;
    if (wr_cyc.size() + rd_cyc.size() != 0) begin
      n_bad++;
      $display("FAIL zero_len_enable got %0d RAM cycles want 0", wr_cyc.size() + rd_cyc.size());
    end
  endtask

  task automatic test_reset_abort();
    words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;
    clear_log();
    @(posedge Clk); #1;
    Start = 1'b1; Base_Addr = 16'h0000; Length = 16'd4;
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      cyc = c; Data_Valid = 1'b1; Data_In = words[c - 1];
      if (c < 3) begin
        @(posedge Clk); #1;
      end
    end
    #2 Reset = 1'b1;
    #1;
    n_cmp++;
    if ({Enable, RW, Address, Ram_In, Data_Ready, Busy, Done, Pass, Checksum} !== ResetVec) begin
      n_bad++;
      $display("FAIL abort_async got %h want %h",
               {Enable, RW, Address, Ram_In, Data_Ready, Busy, Done, Pass, Checksum}, ResetVec);
    end
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b0; Data_Valid = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    n_cmp++;
    if ({wr_cyc.size(), rd_cyc.size(), Busy} !== {2, 0, 1'b0}) begin
      n_bad++;
      $display("FAIL abort_cycles got wr=%0d rd=%0d busy=%b want wr=2 rd=0 busy=0",
               wr_cyc.size(), rd_cyc.size(), Busy);
    end
    n_cmp++;
    if ({mem[0], mem[1], mem[2]} !== {32'h11111111, 32'h22222222, 32'h0}) begin
      n_bad++;
      $display("FAIL abort_mem got %h %h %h want 11111111 22222222 00000000", mem[0], mem[1],
               mem[2]);
    end
    // Fresh load with Start pulsed (with a different base/length) while busy.
    run_load(16'h0000, 16'd4, 1'b0, 1'b1);
    n_cmp++;
    if ({wr_addr.size(), rd_addr.size(), done_cyc} !== {4, 4, 9}) begin
      n_bad++;
      $display("FAIL restart_counts got wr=%0d rd=%0d done=%0d want 4 4 9", wr_addr.size(),
               rd_addr.size(), done_cyc);
    end
    for (int i = 0; i < 4 && i < wr_addr.size() && i < rd_addr.size(); i++) begin
      n_cmp++;
      if ({wr_addr[i], rd_addr[i]} !== {16'(i), 16'(i)}) begin
        n_bad++;
        $display("FAIL restart_addr%0d got wr=%h rd=%h want %h", i, wr_addr[i], rd_addr[i],
                 16'(i));
      end
    end
    n_cmp++;
    if ({pass_at_done, sum_at_done} !== {1'b1, 32'hAAAAAAAA}) begin
      n_bad++;
      $display("FAIL restart_result got pass=%b sum=%h want pass=1 sum=aaaaaaaa", pass_at_done,
               sum_at_done);
    end
  endtask

  // Idle after a completed load: defaults on control, last address/data held, result held.
  task automatic test_hold();
    repeat (3) @(posedge Clk);
    #1;
    n_cmp++;
    if ({Enable, RW, Data_Ready, Busy, Done, Address, Ram_In, Pass, Checksum} !==
        {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 32'h44444444, 1'b1, 32'hAAAAAAAA}) begin
      n_bad++;
      $display("FAIL idle_hold got %h want %h",
               {Enable, RW, Data_Ready, Busy, Done, Address, Ram_In, Pass, Checksum},
               {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 32'h44444444, 1'b1, 32'hAAAAAAAA});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    test_reset();
    test_basic("basic", 1'b0);
    test_basic("stall", 1'b1);
    test_wrap();
    test_corrupt();
    test_zero_len();
    test_reset_abort();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_block_loader.md
# ram_block_loader

Sequential write-side master for the RAM block's Enable/RW/Address/In/Out port. It accepts a stream of 32-bit words over a valid/ready handshake and writes them to consecutive RAM addresses starting at a programmed base. It then reads the same range back and compares a read-back checksum against the write checksum. It sits between a loader source (host, boot ROM, test feeder) and the RAM, replacing hand-driven write sequences.

## Interface
Parameters:
- None. Widths are fixed by the RAM port: address 16 bits, data 32 bits.

Ports:
- Clk  input  1  single system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high; forces IDLE and reset values immediately.
- Start  input  1  begin a load; sampled only in IDLE.
- Base_Addr  input  16  first RAM address; captured on accepted Start.
- Length  input  16  number of words to load; captured on accepted Start; 0 is legal.
- Data_In  input  32  stream word.
- Data_Valid  input  1  Data_In is valid this cycle.
- Data_Ready  output  1  loader accepts Data_In this cycle.
- Enable  output  1  to RAM Enable.
- RW  output  1  to RAM RW; 1 = read, 0 = write.
- Address  output  16  to RAM Address.
- Ram_In  output  32  to RAM In (write data).
- Ram_Out  input  32  from RAM Out. It is combinational: valid in the same cycle as Enable=1, RW=1.
- Busy  output  1  high from the cycle after an accepted Start until Done.
- Done  output  1  one-cycle pulse at the end of the verify phase.
- Pass  output  1  read-back checksum equalled write checksum; held until the next accepted Start.
- Checksum  output  32  write checksum; held until the next accepted Start.

## Operation
- States: IDLE, WRITE, READ, FINISH.
- IDLE:
  - Start=1 latches Base_Addr into the address counter and Length into the remaining count.
  - It clears the write sum, the read sum, Pass and Checksum.
  - Next state is WRITE, or FINISH if Length=0.
- WRITE:
  - Data_Ready=1.
  - In each cycle with Data_Valid=1, the word is accepted and these are driven combinationally: Enable=1, RW=0, Address=counter, Ram_In=Data_In.
  - On that edge: the counter increments, remaining decrements, and the write sum adds Data_In.
  - Data_Valid=0 gives Enable=0 and no state change; stalls are unbounded.
  - After the last word is accepted, the counter reloads Base_Addr, remaining reloads Length, and the state goes to READ.
- READ:
  - Each cycle drives Enable=1, RW=1, Address=counter.
  - On the edge: the read sum adds Ram_Out, the counter increments, remaining decrements.
  - After the last word, the state goes to FINISH.
- FINISH (one cycle):
  - Done=1.
  - Pass registers (read sum == write sum) and Checksum registers the write sum.
  - Next state is IDLE.
- Arithmetic:
  - Sums are 32-bit, modulo 2^32, with carries discarded.
  - The address counter is 16-bit, modulo 2^16: Base_Addr=0xFFFE with Length=3 writes 0xFFFE, 0xFFFF, 0x0000.
- Start while Busy is ignored. The captured Base_Addr and Length do not change mid-operation.
- Default outputs outside active cycles: Enable=0, RW=1, Data_Ready=0. Address and Ram_In hold their last value.

## Timing
- Reset values: Enable 0, RW 1, Address 0, Ram_In 0, Data_Ready 0, Busy 0, Done 0, Pass 0, Checksum 0. State is IDLE.
- Reset mid-operation aborts immediately. No further RAM cycles occur, and a partially written range is left as is.
- Start is sampled at edge 0, and WRITE begins in cycle 1.
- With Data_Valid held high, the timeline for N≥1 words is:
  - writes occupy cycles 1..N;
  - reads occupy cycles N+1..2N;
  - Done pulses in cycle 2N+1;
  - Busy falls in cycle 2N+2.
- For Length=0, Done pulses in cycle 1 with Pass=1 and Checksum=0.
- A handshake transfer occurs only when Data_Valid & Data_Ready are both high at the rising edge.
- Pass and Checksum are stable from the Done cycle onward.

## Test plan
- Load of 4 words, Base 0x0000, data 0x11111111, 0x22222222, 0x33333333, 0x44444444, no stalls:
  - writes at addresses 0..3 in cycles 1..4, reads in cycles 5..8, Done in cycle 9;
  - Checksum=0xAAAAAAAA, Pass=1;
  - RAM Mem[0..3] holds the data.
- Same load with Data_Valid low every other cycle:
  - Enable=0 on the stall cycles, exactly 4 write cycles occur;
  - result identical to the first scenario.
- Base 0xFFFE, Length 3, data 0xFFFFFFFF ×3:
  - addresses 0xFFFE, 0xFFFF, 0x0000 in both phases;
  - Checksum=0xFFFFFFFD (modular wrap), Pass=1.
- Length=0: Done in cycle 1, Pass=1, Checksum=0, and Enable never asserts.
- RAM model that corrupts address 2 on read (bit 0 flipped), 4-word load: Pass=0, Checksum still equals the write sum.
- Reset asserted in cycle 3 of a 4-word load:
  - all outputs return to reset values asynchronously with no further Enable;
  - Start repeated during Busy is ignored;
  - a fresh Start after reset completes normally.
